// File: rtl/lcd_digit_updater.sv
// Feeds the LCD driver's digit write port: converts motor/displacement to BCD and writes only
// the digits that changed, paced so each LCD write and screen refresh completes first.
module lcd_digit_updater #(
   parameter int unsigned STARTUP_CYCLES = 6000,
   parameter int unsigned GAP_CYCLES     = 90000,
   parameter int unsigned GAP_W          = 17
) (
   input  logic       sys_clk,
   input  logic       reset_o,
   input  logic [3:0] motor_id,
   input  logic [9:0] displacement,
   input  logic       update_req,
   output logic       busy,
   output logic [1:0] number_index,
   output logic [3:0] number_in,
   output logic       number_modify_en
);

   localparam logic [GAP_W-1:0] StartupLast = GAP_W'(STARTUP_CYCLES - 1);
   localparam logic [GAP_W-1:0] GapLast     = GAP_W'(GAP_CYCLES - 1);

   typedef enum logic [2:0] {StStartup, StIdle, StConvert, StScan, StGap} state_e;

   state_e            state_q, state_d;
   logic [GAP_W-1:0]  cnt_q, cnt_d;
   logic [3:0]        step_q, step_d;
   logic [1:0]        idx_q, idx_d;
   logic              pending_q, pending_d;
   logic [3:0]        hold_motor_q;
   logic [9:0]        hold_disp_q;
   logic [3:0]        motor_dig_q, motor_dig_d;
   logic [9:0]        bin_q, bin_d;
   logic [11:0]       bcd_q, bcd_d;
   logic [3:0][3:0]   shadow_q, shadow_d;
   logic [3:0][3:0]   digits;
   logic [7:0]        bcd_adj;
   logic              busy_q, busy_d;
   logic [1:0]        index_q, index_d;
   logic [3:0]        in_q, in_d;
   logic              en_q, en_d;

   assign digits = {bcd_q[3:0], bcd_q[7:4], bcd_q[11:8], motor_dig_q};

   // Hundreds never reaches 5 before a shift since the operand is at most 999.
   always_comb begin
      bcd_adj = '0;
      for (int k = 0; k < 2; k++) begin
         bcd_adj[4*k +: 4] = (bcd_q[4*k +: 4] >= 4'd5) ? bcd_q[4*k +: 4] + 4'd3
                                                        : bcd_q[4*k +: 4];
      end
   end

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      step_d      = step_q;
      idx_d       = idx_q;
      pending_d   = pending_q | update_req;
      motor_dig_d = motor_dig_q;
      bin_d       = bin_q;
      bcd_d       = bcd_q;
      shadow_d    = shadow_q;
      index_d     = index_q;
      in_d        = in_q;
      en_d        = 1'b0;
      case (state_q)
         StStartup: begin
            if (cnt_q == StartupLast) begin
               state_d = StIdle;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         StIdle: begin
            pending_d = 1'b0;
            if (update_req || pending_q) begin
               state_d = StConvert;
               step_d  = '0;
            end
         end
         StConvert: begin
            // First cycle snapshots the held request; the next ten are shift-add-3 steps.
            if (step_q == 4'd0) begin
               motor_dig_d = hold_motor_q;
               bin_d       = hold_disp_q;
               bcd_d       = '0;
               step_d      = 4'd1;
            end else begin
               bcd_d = {bcd_q[10:8], bcd_adj, bin_q[9]};
               bin_d = {bin_q[8:0], 1'b0};
               if (step_q == 4'd10) begin
                  state_d = StScan;
                  idx_d   = '0;
               end else begin
                  step_d = step_q + 4'd1;
               end
            end
         end
         StScan: begin
            if (digits[idx_q] != shadow_q[idx_q]) begin
               en_d             = 1'b1;
               index_d          = idx_q;
               in_d             = digits[idx_q];
               shadow_d[idx_q]  = digits[idx_q];
               state_d          = StGap;
               cnt_d            = '0;
            end else if (idx_q == 2'd3) begin
               state_d = StIdle;
            end else begin
               idx_d = idx_q + 2'd1;
            end
         end
         StGap: begin
            if (cnt_q == GapLast) begin
               cnt_d = '0;
               if (idx_q == 2'd3) begin
                  state_d = StIdle;
               end else begin
                  idx_d   = idx_q + 2'd1;
                  state_d = StScan;
               end
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         default: state_d = StStartup;
      endcase
      // A fresh request from idle raises busy one cycle late; queued work keeps it high.
      busy_d = (state_d != StIdle || pending_d) && !(state_q == StIdle && !pending_q);
   end

   always_ff @(posedge sys_clk or negedge reset_o) begin
      if (!reset_o) begin
         state_q      <= StStartup;
         cnt_q        <= '0;
         step_q       <= '0;
         idx_q        <= '0;
         pending_q    <= 1'b0;
         hold_motor_q <= '0;
         hold_disp_q  <= '0;
         motor_dig_q  <= '0;
         bin_q        <= '0;
         bcd_q        <= '0;
         shadow_q     <= 16'h0001;
         busy_q       <= 1'b1;
         index_q      <= '0;
         in_q         <= '0;
         en_q         <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         step_q      <= step_d;
         idx_q       <= idx_d;
         pending_q   <= pending_d;
         motor_dig_q <= motor_dig_d;
         bin_q       <= bin_d;
         bcd_q       <= bcd_d;
         shadow_q    <= shadow_d;
         busy_q      <= busy_d;
         index_q     <= index_d;
         in_q        <= in_d;
         en_q        <= en_d;
         if (update_req) begin
            hold_motor_q <= (motor_id > 4'd9) ? 4'd9 : motor_id;
            hold_disp_q  <= (displacement > 10'd999) ? 10'd999 : displacement;
         end
      end
   end

   assign busy             = busy_q;
   assign number_index     = index_q;
   assign number_in        = in_q;
   assign number_modify_en = en_q;

endmodule

// File: tb/tb_lcd_digit_updater.sv
// Randomised self-checking bench for lcd_digit_updater against a digit-level reference model
// with small startup/gap parameters.
module tb_lcd_digit_updater;

   localparam int S = 200;
   localparam int G = 50;

   logic       sys_clk = 1'b0;
   logic       reset_o;
   logic [3:0] motor_id;
   logic [9:0] displacement;
   logic       update_req;
   logic       busy;
   logic [1:0] number_index;
   logic [3:0] number_in;
   logic       number_modify_en;

   int cyc = 0;
   int checks = 0;
   int errors = 0;
   int pulse_cyc[$], pulse_idx[$], pulse_val[$], fall_cyc[$];
   int exp_cyc[$], exp_idx[$], exp_val[$];
   int sh[4];
   logic busy_prev = 1'b1;

   lcd_digit_updater #(
      .STARTUP_CYCLES(S),
      .GAP_CYCLES    (G),
      .GAP_W         (17)
   ) dut (
      .sys_clk         (sys_clk),
      .reset_o         (reset_o),
      .motor_id        (motor_id),
      .displacement    (displacement),
      .update_req      (update_req),
      .busy            (busy),
      .number_index    (number_index),
      .number_in       (number_in),
      .number_modify_en(number_modify_en)
   );

   always #5 sys_clk = ~sys_clk;

   always @(posedge sys_clk) cyc <= cyc + 1;

   // Pulses and busy falls are stamped with the number of rising edges seen so far.
   always @(negedge sys_clk) begin
      if (number_modify_en === 1'b1) begin
         pulse_cyc.push_back(cyc);
         pulse_idx.push_back(int'(number_index));
         pulse_val.push_back(int'(number_in));
      end
      if (busy_prev === 1'b1 && busy === 1'b0) fall_cyc.push_back(cyc);
      busy_prev <= busy;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not complete, errors so far %0d", errors);
      $fatal(1);
   end

   task automatic clear_obs();
      pulse_cyc.delete(); pulse_idx.delete(); pulse_val.delete(); fall_cyc.delete();
      exp_cyc.delete(); exp_idx.delete(); exp_val.delete();
   endtask

   // Request accepted at edge n: digit 0 decided at n+12, each later digit one cycle on,
   // plus a gap after each write. Returns the edge at which busy falls.
   task automatic model_request(input int n, input int m, input int d, output int t_end);
      int dig[4];
      int t;
      if (m > 9) m = 9;
      if (d > 999) d = 999;
      dig = '{m, d / 100, (d / 10) % 10, d % 10};
      t = n + 11;
      for (int i = 0; i < 4; i++) begin
         t++;
         if (dig[i] != sh[i]) begin
            exp_cyc.push_back(t);
            exp_idx.push_back(i);
            exp_val.push_back(dig[i]);
            sh[i] = dig[i];
            t += G;
         end
      end
      t_end = t;
   endtask

   task automatic pulse_req(input int m, input int d);
      @(negedge sys_clk);
      motor_id = 4'(m);
      displacement = 10'(d);
      update_req = 1'b1;
      @(negedge sys_clk);
      update_req = 1'b0;
      motor_id = 4'($urandom);
      displacement = 10'($urandom);
   endtask

   task automatic test_reset();
      reset_o = 1'b0;
      update_req = 1'b0;
      motor_id = '0;
      displacement = '0;
      sh = '{1, 0, 0, 0};
      repeat (3) @(negedge sys_clk);
      checks++;
      if (busy !== 1'b1) begin
         errors++; $display("FAIL reset_busy: got %b, expected 1", busy);
      end
      checks++;
      if (number_modify_en !== 1'b0) begin
         errors++; $display("FAIL reset_en: got %b, expected 0", number_modify_en);
      end
      checks++;
      if (number_index !== 2'd0 || number_in !== 4'd0) begin
         errors++;
         $display("FAIL reset_digit: got idx %0d val %0d, expected 0 0", number_index, number_in);
      end
   endtask

   task automatic test_startup_hold();
      int r, n, t_end;
      clear_obs();
      reset_o = 1'b1;
      r = cyc;
      while (cyc < r + 99) @(negedge sys_clk);
      pulse_req(3, 0);
      n = r + S + 1;
      model_request(n, 3, 0, t_end);
      while (cyc < t_end + 3) @(negedge sys_clk);
      checks++;
      if (pulse_cyc.size() > 0 && pulse_cyc[0] <= r + S) begin
         errors++; $display("FAIL startup_hold: pulse at %0d, startup ends %0d", pulse_cyc[0], r + S);
      end
      checks++;
      if (pulse_cyc.size() != exp_cyc.size()) begin
         errors++;
         $display("FAIL startup_count: got %0d pulses, expected %0d", pulse_cyc.size(), exp_cyc.size());
      end
      for (int i = 0; i < exp_cyc.size() && i < pulse_cyc.size(); i++) begin
         checks++;
         if (pulse_cyc[i] != exp_cyc[i] || pulse_idx[i] != exp_idx[i] || pulse_val[i] != exp_val[i]) begin
            errors++;
            $display("FAIL startup_pulse%0d: got cyc %0d idx %0d val %0d, expected cyc %0d idx %0d val %0d",
                     i, pulse_cyc[i], pulse_idx[i], pulse_val[i], exp_cyc[i], exp_idx[i], exp_val[i]);
         end
      end
      checks++;
      if (fall_cyc.size() != 1 || fall_cyc[0] != t_end) begin
         errors++;
         $display("FAIL startup_busy: got %0d falls first at %0d, expected one fall at %0d",
                  fall_cyc.size(), (fall_cyc.size() > 0) ? fall_cyc[0] : -1, t_end);
      end
   endtask

   task automatic test_update(input string name, input int m, input int d);
      int n, t_end;
      clear_obs();
      pulse_req(m, d);
      n = cyc;
      checks++;
      if (busy !== 1'b0) begin
         errors++; $display("FAIL %s busy_at_req: got %b, expected 0", name, busy);
      end
      @(negedge sys_clk);
      checks++;
      if (busy !== 1'b1) begin
         errors++; $display("FAIL %s busy_rise: got %b, expected 1", name, busy);
      end
      model_request(n, m, d, t_end);
      while (cyc < t_end + 3) @(negedge sys_clk);
      checks++;
      if (pulse_cyc.size() != exp_cyc.size()) begin
         errors++;
         $display("FAIL %s count: got %0d pulses, expected %0d", name, pulse_cyc.size(), exp_cyc.size());
      end
      for (int i = 0; i < exp_cyc.size() && i < pulse_cyc.size(); i++) begin
         checks++;
         if (pulse_cyc[i] != exp_cyc[i] || pulse_idx[i] != exp_idx[i] || pulse_val[i] != exp_val[i]) begin
            errors++;
            $display("FAIL %s pulse%0d: got cyc %0d idx %0d val %0d, expected cyc %0d idx %0d val %0d",
                     name, i, pulse_cyc[i] - n, pulse_idx[i], pulse_val[i], exp_cyc[i] - n,
                     exp_idx[i], exp_val[i]);
         end
      end
      checks++;
      if (fall_cyc.size() != 1 || fall_cyc[0] != t_end) begin
         errors++;
         $display("FAIL %s busy_fall: got %0d falls first at +%0d, expected one at +%0d", name,
                  fall_cyc.size(), (fall_cyc.size() > 0) ? fall_cyc[0] - n : -1, t_end - n);
      end
   endtask

   task automatic test_random_updates();
      for (int k = 0; k < 6; k++) begin
         test_update("random", int'($urandom_range(0, 15)), int'($urandom_range(0, 1023)));
      end
   endtask

   task automatic test_back_to_back();
      int n, m_a, t_a, t_b;
      clear_obs();
      m_a = (sh[0] + 1) % 10;
      pulse_req(m_a, 100);
      n = cyc;
      while (cyc < n + 20) @(negedge sys_clk);
      pulse_req(m_a, 250);
      while (cyc < n + 25) @(negedge sys_clk);
      pulse_req(m_a, 251);
      model_request(n, m_a, 100, t_a);
      model_request(t_a + 1, m_a, 251, t_b);
      while (cyc < t_b + 3) @(negedge sys_clk);
      checks++;
      if (pulse_cyc.size() != exp_cyc.size()) begin
         errors++;
         $display("FAIL b2b_count: got %0d pulses, expected %0d", pulse_cyc.size(), exp_cyc.size());
      end
      for (int i = 0; i < exp_cyc.size() && i < pulse_cyc.size(); i++) begin
         checks++;
         if (pulse_cyc[i] != exp_cyc[i] || pulse_idx[i] != exp_idx[i] || pulse_val[i] != exp_val[i]) begin
            errors++;
            $display("FAIL b2b_pulse%0d: got cyc %0d idx %0d val %0d, expected cyc %0d idx %0d val %0d",
                     i, pulse_cyc[i] - n, pulse_idx[i], pulse_val[i], exp_cyc[i] - n, exp_idx[i],
                     exp_val[i]);
         end
      end
      checks++;
      if (fall_cyc.size() != 1 || fall_cyc[0] != t_b) begin
         errors++;
         $display("FAIL b2b_busy: got %0d falls first at +%0d, expected one at +%0d",
                  fall_cyc.size(), (fall_cyc.size() > 0) ? fall_cyc[0] - n : -1, t_b - n);
      end
   endtask

   task automatic test_reset_mid_gap();
      int n, r, hn;
      clear_obs();
      hn = (sh[1] + 1) % 10;
      pulse_req(sh[0], hn * 100 + sh[2] * 10 + sh[3]);
      n = cyc;
      while (cyc < n + 20) @(negedge sys_clk);
      checks++;
      if (number_index !== 2'd1 || number_in !== 4'(hn)) begin
         errors++;
         $display("FAIL midgap_pre: got idx %0d val %0d, expected 1 %0d", number_index, number_in, hn);
      end
      pulse_req(7, 777);
      while (cyc < n + 30) @(negedge sys_clk);
      @(posedge sys_clk);
      #2 reset_o = 1'b0;
      #1;
      checks++;
      if (busy !== 1'b1 || number_modify_en !== 1'b0) begin
         errors++;
         $display("FAIL midgap_reset_ctl: got busy %b en %b, expected 1 0", busy, number_modify_en);
      end
      checks++;
      if (number_index !== 2'd0 || number_in !== 4'd0) begin
         errors++;
         $display("FAIL midgap_reset_digit: got idx %0d val %0d, expected 0 0", number_index, number_in);
      end
      sh = '{1, 0, 0, 0};
      repeat (3) @(negedge sys_clk);
      reset_o = 1'b1;
      r = cyc;
      clear_obs();
      while (cyc < r + S + 4) @(negedge sys_clk);
      checks++;
      if (busy !== 1'b0 || pulse_cyc.size() != 0) begin
         errors++;
         $display("FAIL midgap_pending_cleared: got busy %b pulses %0d, expected 0 0", busy,
                  pulse_cyc.size());
      end
      test_update("reset_shadow", 1, 0);
   endtask

   initial begin
      test_reset();
      test_startup_hold();
      test_update("sparse_507", 3, 507);
      test_update("saturate", 12, 1023);
      test_update("no_change", 12, 1023);
      test_random_updates();
      test_back_to_back();
      test_reset_mid_gap();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/lcd_digit_updater.md
Name: lcd_digit_updater

Overview:
- Sits directly upstream of the LCD display driver; generates its number_index / number_in / number_modify_en write stream.
- Accepts motor ID (0-9) and displacement (0-999) values in binary and converts displacement to BCD with a sequential double-dabble.
- Sends only the digits that differ from the currently displayed values, one pulse at a time, spaced so each LCD point-matrix write plus full-screen refresh finishes before the next pulse.
- Also holds off all writes until LCD power-up initialisation is complete.

Parameters:
- STARTUP_CYCLES, 6000: sys_clk cycles after reset release before the first write is allowed. Covers LCD reset wait, reset pulse and init at 12 MHz.
- GAP_CYCLES, 90000: idle cycles after every number_modify_en pulse. Covers RAM rewrite plus the 81920-cycle screen refresh.
- GAP_W, 17: counter width. Must hold max(STARTUP_CYCLES, GAP_CYCLES).

Ports:
- sys_clk  input  1  system clock, 12 MHz
- reset_o  input  1  reset, asynchronous, active-low
- motor_id  input  4  motor number; values >9 saturate to 9
- displacement  input  10  displacement in binary; values >999 saturate to 999
- update_req  input  1  one-cycle pulse; sample motor_id/displacement and update the display
- busy  output  1  high from request acceptance until the last gap expires
- number_index  output  2  digit position: 0 = motor, 1 = hundreds, 2 = tens, 3 = units
- number_in  output  4  BCD digit value, 0-9
- number_modify_en  output  1  one-cycle write strobe to the LCD driver

Behaviour:
- Reset (reset_o low, async):
  - State STARTUP, gap counter cleared.
  - busy=1, number_modify_en=0, number_index=0, number_in=0, pending=0.
  - Shadow digits = {1,0,0,0}, matching the LCD driver power-up contents.
- States:
  - STARTUP: counts STARTUP_CYCLES, then goes to IDLE. update_req seen here sets pending; inputs are sampled at the request edge.
  - IDLE: busy=0. On update_req, or pending=1, latch saturated inputs, clear pending, go to CONVERT; busy=1 from the next cycle.
  - CONVERT: exactly 10 cycles of shift-add-3 on a 12-bit BCD accumulator, then SCAN with scan index=0.
  - SCAN: one cycle per index.
    - If new digit[idx] != shadow[idx]: register number_index=idx, number_in=digit, assert number_modify_en for exactly one cycle, update shadow[idx], go to GAP.
    - Otherwise idx+1.
    - After idx 3 is checked with no write, go to IDLE.
  - GAP: count GAP_CYCLES. Then idx+1 → SCAN, or → IDLE if idx was 3.
- Latency: with update_req sampled at edge N from IDLE and digit 0 differing, number_modify_en is high in the cycle following edge N+12. Each skipped (equal) digit adds 1 cycle.
- Outputs are registered; number_index/number_in hold their values until the next pulse.
- Requests during busy:
  - Set pending, one deep; the latest inputs overwrite the held inputs.
  - Serviced on the IDLE entry cycle without an idle gap; busy stays high.
- Simultaneous update_req and transition to IDLE: treated as pending, no request lost.
- No-change request: CONVERT+SCAN run (14 cycles busy), zero pulses.
- Reset mid-operation: immediately returns to STARTUP; shadow reloads {1,0,0,0}; any partial update is abandoned.
- number_modify_en is never asserted in STARTUP, CONVERT or GAP.
- Minimum spacing between pulses is GAP_CYCLES+1.

Test Plan:
- Reset release, update_req at cycle 100 with motor_id=3, displacement=0 → no pulse before STARTUP_CYCLES. Then exactly one pulse (index 0, value 3); busy drops after the gap.
- After idle, displacement=507, motor_id=3 → pulses (1,5) and (3,7) only, in that order, GAP_CYCLES+2 cycles apart. Index 2 is skipped since tens=0 already.
- displacement=1023, motor_id=12 → saturation: digits 9,9,9,9, four pulses with values 9.
- Same inputs re-requested → busy high for 14 cycles, zero number_modify_en pulses.
- Two update_req pulses during a gap (displacement 250 then 251) → only 251 is applied after the current sequence completes; 250 is never displayed.
- reset_o low during a GAP with a pending request → outputs return to reset values within the same cycle; pending is cleared; the shadow-driven next update to {1,0,0,0} produces zero pulses.
